// File: rtl/reg_scoreboard.sv
// Register-write scoreboard: per-register pending-write counters for x1..x31,
// decode stall generation for RAW hazards and counter saturation.
module reg_scoreboard #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned TOT_W = 7
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             reg_ren1_dec,
    input  logic [4:0]       reg_raddr1_dec,
    input  logic             reg_ren2_dec,
    input  logic [4:0]       reg_raddr2_dec,
    input  logic             issue_valid_dec,
    input  logic             issue_wen_dec,
    input  logic [4:0]       issue_waddr_dec,
    input  logic             reg_wen_wb,
    input  logic [4:0]       reg_waddr_wb,
    input  logic             flush_sb,
    output logic             stall_dec,
    output logic             sb_busy,
    output logic [TOT_W-1:0] pend_total,
    output logic             err_underflow
);

    localparam int unsigned NREG = 32;
    localparam int unsigned AW   = 5;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             raw1;
    logic             raw2;
    logic             sat;
    logic             issue_fire;
    logic             rel;
    logic             rel_nz;
    logic             underflow;
    logic [TOT_W-1:0] total_d;

    // Hazard detection uses pre-edge counts; x0 never participates.
    assign raw1       = reg_ren1_dec && (reg_raddr1_dec != '0) && (cnt_q[reg_raddr1_dec] != '0);
    assign raw2       = reg_ren2_dec && (reg_raddr2_dec != '0) && (cnt_q[reg_raddr2_dec] != '0);
    assign sat        = issue_valid_dec && issue_wen_dec && (issue_waddr_dec != '0)
                        && (cnt_q[issue_waddr_dec] == CNT_MAX);
    assign stall_dec  = issue_valid_dec && (raw1 || raw2 || sat);
    assign issue_fire = issue_valid_dec && !stall_dec && issue_wen_dec && (issue_waddr_dec != '0);
    assign rel        = reg_wen_wb && (reg_waddr_wb != '0);
    assign rel_nz     = rel && (cnt_q[reg_waddr_wb] != '0);
    assign underflow  = rel && !flush_sb && (cnt_q[reg_waddr_wb] == '0);

    // Next-state counters and total; a flush discards same-cycle issue/release.
    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            cnt_d[i] = cnt_q[i];
        end
        total_d = pend_total;
        if (flush_sb) begin
            for (int i = 0; i < int'(NREG); i++) begin
                cnt_d[i] = '0;
            end
            total_d = '0;
        end else begin
            total_d = pend_total + TOT_W'(issue_fire) - TOT_W'(rel_nz);
            for (int i = 1; i < int'(NREG); i++) begin
                if (issue_fire && (issue_waddr_dec == AW'(i))
                    && !(rel_nz && (reg_waddr_wb == AW'(i)))) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end else if (rel_nz && (reg_waddr_wb == AW'(i))
                    && !(issue_fire && (issue_waddr_dec == AW'(i)))) begin
                    cnt_d[i] = cnt_q[i] - CNT_W'(1);
                end
            end
        end
    end

    // State registers; err_underflow is sticky until reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < int'(NREG); i++) begin
                cnt_q[i] <= '0;
            end
            pend_total    <= '0;
            sb_busy       <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            for (int i = 0; i < int'(NREG); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            pend_total <= total_d;
            sb_busy    <= (total_d != '0);
            if (underflow) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus random traffic
// checked every cycle against a counter-array reference model.
module tb_reg_scoreboard;

    localparam int unsigned CNT_W = 2;
    localparam int unsigned TOT_W = 7;
    localparam int          MAXC  = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_b;
    logic             reg_ren1_dec;
    logic [4:0]       reg_raddr1_dec;
    logic             reg_ren2_dec;
    logic [4:0]       reg_raddr2_dec;
    logic             issue_valid_dec;
    logic             issue_wen_dec;
    logic [4:0]       issue_waddr_dec;
    logic             reg_wen_wb;
    logic [4:0]       reg_waddr_wb;
    logic             flush_sb;
    logic             stall_dec;
    logic             sb_busy;
    logic [TOT_W-1:0] pend_total;
    logic             err_underflow;

    int mcnt [32];
    bit merr;
    int errors;
    int checks;

    reg_scoreboard #(.CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
        .clk             (clk),
        .rst_b           (rst_b),
        .reg_ren1_dec    (reg_ren1_dec),
        .reg_raddr1_dec  (reg_raddr1_dec),
        .reg_ren2_dec    (reg_ren2_dec),
        .reg_raddr2_dec  (reg_raddr2_dec),
        .issue_valid_dec (issue_valid_dec),
        .issue_wen_dec   (issue_wen_dec),
        .issue_waddr_dec (issue_waddr_dec),
        .reg_wen_wb      (reg_wen_wb),
        .reg_waddr_wb    (reg_waddr_wb),
        .flush_sb        (flush_sb),
        .stall_dec       (stall_dec),
        .sb_busy         (sb_busy),
        .pend_total      (pend_total),
        .err_underflow   (err_underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_total();
        int s = 0;
        for (int i = 0; i < 32; i++) s += mcnt[i];
        return s;
    endfunction

    function automatic bit m_stall();
        bit r1, r2, st;
        r1 = reg_ren1_dec && reg_raddr1_dec != 0 && mcnt[reg_raddr1_dec] != 0;
        r2 = reg_ren2_dec && reg_raddr2_dec != 0 && mcnt[reg_raddr2_dec] != 0;
        st = issue_wen_dec && issue_waddr_dec != 0 && mcnt[issue_waddr_dec] == MAXC;
        return issue_valid_dec && (r1 || r2 || st);
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
        merr = 1'b0;
    endtask

    // Apply the clock-edge rules to the model using the inputs held across the edge.
    task automatic m_update();
        bit fire;
        if (!rst_b) return;
        if (flush_sb) begin
            for (int i = 0; i < 32; i++) mcnt[i] = 0;
            return;
        end
        fire = issue_valid_dec && !m_stall() && issue_wen_dec && issue_waddr_dec != 0;
        if (reg_wen_wb && reg_waddr_wb != 0) begin
            if (mcnt[reg_waddr_wb] == 0) merr = 1'b1;
            else mcnt[reg_waddr_wb]--;
        end
        if (fire) mcnt[issue_waddr_dec]++;
    endtask

    task automatic tick();
        @(posedge clk);
        m_update();
        #1;
    endtask

    task automatic idle();
        reg_ren1_dec = 0; reg_raddr1_dec = 0; reg_ren2_dec = 0; reg_raddr2_dec = 0;
        issue_valid_dec = 0; issue_wen_dec = 0; issue_waddr_dec = 0;
        reg_wen_wb = 0; reg_waddr_wb = 0; flush_sb = 0;
    endtask

    task automatic issue(input int r);
        idle();
        issue_valid_dec = 1; issue_wen_dec = 1; issue_waddr_dec = 5'(r);
    endtask

    task automatic release_reg(input int r);
        reg_wen_wb = 1; reg_waddr_wb = 5'(r);
    endtask

    task automatic do_reset();
        #1;
        rst_b = 1'b0;
        m_clear();
        #2;
        rst_b = 1'b1;
    endtask

    // Per-cycle comparison of every output against the model.
    initial begin
        forever begin
            @(negedge clk);
            chk("stall_dec", int'(stall_dec), int'(m_stall()));
            chk("pend_total", int'(pend_total), m_total());
            chk("sb_busy", int'(sb_busy), int'(m_total() != 0));
            chk("err_underflow", int'(err_underflow), int'(merr));
        end
    end

    initial begin
        errors = 0;
        checks = 0;
        m_clear();
        idle();
        rst_b = 1'b0;
        #12 rst_b = 1'b1;
        #1;
        chk("rst_pend", int'(pend_total), 0);
        chk("rst_busy", int'(sb_busy), 0);
        chk("rst_err", int'(err_underflow), 0);
        chk("rst_stall", int'(stall_dec), 0);

        // RAW on x5 until its writeback edge
        issue(5); tick();
        chk("x5_pend", int'(pend_total), 1);
        chk("x5_busy", int'(sb_busy), 1);
        idle(); issue_valid_dec = 1; reg_ren1_dec = 1; reg_raddr1_dec = 5;
        #1 chk("x5_raw", int'(stall_dec), 1);
        tick(); tick();
        release_reg(5);
        #1 chk("x5_raw_wb", int'(stall_dec), 1);
        tick();
        reg_wen_wb = 0;
        #1 chk("x5_go", int'(stall_dec), 0);
        chk("x5_pend0", int'(pend_total), 0);
        chk("x5_busy0", int'(sb_busy), 0);
        tick();

        // Saturation on x7
        issue(7); tick(); tick(); tick();
        chk("x7_pend3", int'(pend_total), 3);
        #1 chk("x7_sat", int'(stall_dec), 1);
        tick();
        chk("x7_hold", int'(pend_total), 3);
        release_reg(7);
        #1 chk("x7_sat_rel", int'(stall_dec), 1);
        tick();
        chk("x7_pend2", int'(pend_total), 2);
        reg_wen_wb = 0;
        #1 chk("x7_fire", int'(stall_dec), 0);
        tick();
        chk("x7_back3", int'(pend_total), 3);
        idle(); release_reg(7); tick(); tick(); tick();
        idle();
        chk("x7_drain", int'(pend_total), 0);

        // Same-cycle issue and release
        issue(9); tick();
        issue(9); release_reg(9); tick();
        chk("x9_same", int'(pend_total), 1);
        issue(4); tick();
        issue(3); release_reg(4); tick();
        chk("x3x4_pend", int'(pend_total), 2);
        idle(); issue_valid_dec = 1; reg_ren1_dec = 1; reg_raddr1_dec = 3;
        reg_ren2_dec = 1; reg_raddr2_dec = 4;
        #1 chk("x3_pending", int'(stall_dec), 1);
        reg_ren1_dec = 0;
        #1 chk("x4_clear", int'(stall_dec), 0);
        idle(); release_reg(3); tick(); release_reg(9); tick(); idle();

        // Underflow is sticky across flush, cleared by reset
        release_reg(12); tick(); idle();
        chk("uf_set", int'(err_underflow), 1);
        chk("uf_pend", int'(pend_total), 0);
        flush_sb = 1; tick(); idle();
        chk("uf_flush", int'(err_underflow), 1);
        do_reset();
        chk("uf_reset", int'(err_underflow), 0);

        // Flush discards everything including a same-cycle issue
        issue(1); tick(); issue(2); tick(); issue(31); tick();
        chk("fl_pend3", int'(pend_total), 3);
        issue(6); flush_sb = 1; tick(); idle();
        chk("fl_pend0", int'(pend_total), 0);
        chk("fl_busy0", int'(sb_busy), 0);
        issue_valid_dec = 1; reg_ren1_dec = 1; reg_raddr1_dec = 6;
        #1 chk("fl_x6", int'(stall_dec), 0);
        tick();

        // x0 never stalls or counts; async reset drops a stall immediately
        issue(0); reg_ren1_dec = 1; reg_ren2_dec = 1;
        #1 chk("x0_stall", int'(stall_dec), 0);
        tick();
        chk("x0_pend", int'(pend_total), 0);
        issue(8); tick();
        idle(); issue_valid_dec = 1; reg_ren2_dec = 1; reg_raddr2_dec = 8;
        #1 chk("x8_raw", int'(stall_dec), 1);
        rst_b = 1'b0;
        m_clear();
        #1 chk("rst_mid", int'(stall_dec), 0);
        #1 rst_b = 1'b1;
        tick();

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            idle();
            issue_valid_dec = ($urandom_range(0, 9) < 7);
            issue_wen_dec   = ($urandom_range(0, 3) != 0);
            issue_waddr_dec = 5'($urandom_range(0, 7));
            reg_ren1_dec    = $urandom_range(0, 1);
            reg_raddr1_dec  = 5'($urandom_range(0, 7));
            reg_ren2_dec    = $urandom_range(0, 1);
            reg_raddr2_dec  = 5'($urandom_range(0, 7));
            reg_wen_wb      = ($urandom_range(0, 9) < 4);
            reg_waddr_wb    = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 9) != 0) begin
                for (int k = 0; k < 8; k++) begin
                    int r = $urandom_range(1, 7);
                    if (mcnt[r] != 0) begin
                        reg_waddr_wb = 5'(r);
                        break;
                    end
                end
            end
            flush_sb = ($urandom_range(0, 49) == 0);
            if (c % 300 == 299) do_reset();
            tick();
        end
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
